// File: rtl/mult_seq.sv
// mult_seq: sequential 32x32 -> 64-bit shift-and-add multiplier.
// It does not contain its own adder. Each RUN cycle it borrows an external
// combinational ALU through alu_a/alu_b/alu_ctrl/alu_out, so one add costs
// one cycle. A full multiply takes 32 RUN cycles.
//
// Optional feature: define MULT_SEQ_SIGNED_EN to add the signed_op port and
// the FIX state for two's-complement multiplication. In signed mode the core
// multiplies magnitudes, and FIX negates the 64-bit product when needed.
// When MULT_SEQ_SIGNED_EN is undefined, the block is unsigned only.

module mult_seq #(
  parameter logic [3:0] ADD_CODE = 4'd2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_ctrl,
  input  logic [31:0] alu_out
`ifdef MULT_SEQ_SIGNED_EN
  ,
  input  logic        signed_op
`endif
);

  // FIX exists only when signed support is built in. DONE keeps the same
  // encoding in both builds.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
`ifdef MULT_SEQ_SIGNED_EN
    ST_FIX  = 2'd2,
`endif
    ST_DONE = 2'd3
  } state_t;

  localparam logic [4:0] LAST_STEP = 5'd31;

  state_t      state_q, state_d;
  logic [31:0] m_q, m_d;
  logic [31:0] p_hi_q, p_hi_d;
  logic [31:0] p_lo_q, p_lo_d;
  logic [4:0]  count_q, count_d;
`ifdef MULT_SEQ_SIGNED_EN
  logic        neg_q, neg_d;
  logic [63:0] neg_prod;
`endif

  logic        accept;
  logic        carry;
  logic [31:0] load_a;
  logic [31:0] load_b;

  // Operand conditioning at start. In signed mode, take magnitudes.
  // 0x80000000 negates to itself, which is the correct unsigned magnitude.
  always_comb begin
    load_a = op_a;
    load_b = op_b;
`ifdef MULT_SEQ_SIGNED_EN
    if (signed_op && op_a[31]) load_a = 32'd0 - op_a;
    if (signed_op && op_b[31]) load_b = 32'd0 - op_b;
`endif
  end

`ifdef MULT_SEQ_SIGNED_EN
  // Two's-complement negation of the full product, used in FIX.
  always_comb begin
    neg_prod = 64'd0 - {p_hi_q, p_lo_q};
  end
`endif

  // Next-state logic, datapath updates and output decode for the sequencer.
  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    p_hi_d   = p_hi_q;
    p_lo_d   = p_lo_q;
    count_d  = count_q;
`ifdef MULT_SEQ_SIGNED_EN
    neg_d    = neg_q;
`endif
    busy     = 1'b0;
    done     = 1'b0;
    alu_a    = 32'd0;
    alu_b    = 32'd0;
    alu_ctrl = ADD_CODE;
    carry    = 1'b0;
    accept   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_RUN;
      end

      ST_RUN: begin
        busy  = 1'b1;
        alu_a = p_hi_q;
        alu_b = p_lo_q[0] ? m_q : 32'd0;
        // An unsigned add wrapped exactly when the sum is below an operand.
        carry = (alu_out < p_hi_q);
        // {P_hi,P_lo} <= {carry, alu_out, P_lo} >> 1
        p_hi_d  = {carry, alu_out[31:1]};
        p_lo_d  = {alu_out[0], p_lo_q[31:1]};
        count_d = count_q + 5'd1;
        if (count_q == LAST_STEP) begin
`ifdef MULT_SEQ_SIGNED_EN
          state_d = ST_FIX;
`else
          state_d = ST_DONE;
`endif
        end
      end

`ifdef MULT_SEQ_SIGNED_EN
      ST_FIX: begin
        busy = 1'b1;
        if (neg_q) begin
          p_hi_d = neg_prod[63:32];
          p_lo_d = neg_prod[31:0];
        end
        state_d = ST_DONE;
      end
`endif

      ST_DONE: begin
        done    = 1'b1;
        state_d = accept ? ST_RUN : ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // An accepted start reloads the operands. This can happen from IDLE or
    // DONE, so a new multiply can follow a done pulse directly.
    if (accept) begin
      m_d     = load_b;
      p_hi_d  = 32'd0;
      p_lo_d  = load_a;
      count_d = 5'd0;
`ifdef MULT_SEQ_SIGNED_EN
      neg_d   = signed_op && (op_a[31] ^ op_b[31]);
`endif
    end
  end

  // State and datapath registers. Reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      m_q     <= 32'd0;
      p_hi_q  <= 32'd0;
      p_lo_q  <= 32'd0;
      count_q <= 5'd0;
`ifdef MULT_SEQ_SIGNED_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      p_hi_q  <= p_hi_d;
      p_lo_q  <= p_lo_d;
      count_q <= count_d;
`ifdef MULT_SEQ_SIGNED_EN
      neg_q   <= neg_d;
`endif
    end
  end

  // The product register drives the result directly. It holds its value
  // until the next accepted start.
  always_comb begin
    hi = p_hi_q;
    lo = p_lo_q;
  end

endmodule

// File: tb/tb_mult_seq.sv
// tb_mult_seq: directed, table-driven bench for mult_seq with a behavioural
// ALU model that serves the borrowed add port.

module tb_mult_seq;

  localparam logic [3:0] ADD_CODE = 4'd2;
`ifdef MULT_SEQ_SIGNED_EN
  localparam int EXP_LAT = 33;
`else
  localparam int EXP_LAT = 32;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_out;
`ifdef MULT_SEQ_SIGNED_EN
  logic        signedOp = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  int latency;
  int busyCycles;
  bit gotDone;
  logic [31:0] firstAluA;
  logic [31:0] firstAluB;
  logic [3:0]  firstAluCtrl;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] prod;
  } vec_t;

  vec_t vecs[8];

  mult_seq #(.ADD_CODE(ADD_CODE)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op_a     (op_a),
    .op_b     (op_b),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_ctrl (alu_ctrl),
    .alu_out  (alu_out)
`ifdef MULT_SEQ_SIGNED_EN
    ,
    .signed_op(signedOp)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural shared ALU. It adds only on the expected add code.
  assign alu_out = (alu_ctrl == ADD_CODE) ? (alu_a + alu_b) : 32'hDEAD_BEEF;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // Launch one multiply and wait, within a bounded time, for done.
  // injectAt > 0 re-asserts start with other operands at that RUN cycle.
  // abortAt > 0 pulls reset low at that RUN cycle and then returns.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic s, input int injectAt,
                               input int abortAt);
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
`ifdef MULT_SEQ_SIGNED_EN
    signedOp = s;
`else
    if (s) $display("[TB] signed request ignored in unsigned build");
`endif
    @(posedge clk);
    #1;
    start        = 1'b0;
    firstAluA    = alu_a;
    firstAluB    = alu_b;
    firstAluCtrl = alu_ctrl;
    busyCycles   = busy ? 1 : 0;
    latency      = 0;
    gotDone      = 1'b0;
    for (int i = 0; i < 100 && !gotDone; i++) begin
      @(posedge clk);
      #1;
      latency++;
      start = 1'b0;
      if (done) gotDone = 1'b1;
      else if (busy) busyCycles++;
      if (!gotDone && latency == injectAt) begin
        op_a  = 32'd2;
        op_b  = 32'd2;
        start = 1'b1;
      end
      if (!gotDone && latency == abortAt) begin
        rst_n = 1'b0;
        #1;
        checkOutput("abortBusy", {63'd0, busy}, 64'd0);
        checkOutput("abortDone", {63'd0, done}, 64'd0);
        checkOutput("abortHi", {32'd0, hi}, 64'd0);
        checkOutput("abortLo", {32'd0, lo}, 64'd0);
        return;
      end
    end
    start = 1'b0;
    checkOutput("doneSeen", {63'd0, gotDone}, 64'd1);
  endtask

  // Check the result and the timing, then confirm that done is a single
  // pulse and that the result holds.
  task automatic checkResult(input string name, input logic [63:0] prod,
                             input bool_follow);
    checkOutput({name, "_prod"}, {hi, lo}, prod);
    checkOutput({name, "_lat"}, 64'(latency), 64'(EXP_LAT));
    checkOutput({name, "_busy"}, 64'(busyCycles), 64'(EXP_LAT));
    checkOutput({name, "_aluIdle"}, {alu_a, alu_b}, 64'd0);
    if (!bool_follow) begin
      @(posedge clk);
      #1;
      checkOutput({name, "_donePulse"}, {63'd0, done}, 64'd0);
      checkOutput({name, "_held"}, {hi, lo}, prod);
    end
  endtask

  initial begin
    vecs[0] = '{"3x5",       32'd3,          32'd5,          64'h0000_0000_0000_000F};
    vecs[1] = '{"maxSq",     32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{"zeroA",     32'd0,          32'h1234_5678,  64'd0};
    vecs[3] = '{"msbx2",     32'h8000_0000,  32'd2,          64'h0000_0001_0000_0000};
    vecs[4] = '{"shift4",    32'h1234_5678,  32'h10,         64'h0000_0001_2345_6780};
    vecs[5] = '{"maxx1",     32'hFFFF_FFFF,  32'd1,          64'h0000_0000_FFFF_FFFF};
    vecs[6] = '{"halfSq",    32'h0001_0000,  32'h0001_0000,  64'h0000_0001_0000_0000};
    vecs[7] = '{"1000sq",    32'd1000,       32'd1000,       64'h0000_0000_000F_4240};

    // Reset state is visible while rst_n is held low.
    #1;
    checkOutput("rstBusy", {63'd0, busy}, 64'd0);
    checkOutput("rstDone", {63'd0, done}, 64'd0);
    checkOutput("rstHiLo", {hi, lo}, 64'd0);
    checkOutput("rstAlu", {alu_a, alu_b}, 64'd0);
    checkOutput("rstCtrl", {60'd0, alu_ctrl}, {60'd0, ADD_CODE});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Table-driven unsigned vectors.
    for (int v = 0; v < 8; v++) begin
      applyStimulus(vecs[v].a, vecs[v].b, 1'b0, 0, 0);
      if (v == 0) begin
        checkOutput("run0AluA", {32'd0, firstAluA}, 64'd0);
        checkOutput("run0AluB", {32'd0, firstAluB}, 64'd5);
        checkOutput("run0Ctrl", {60'd0, firstAluCtrl}, {60'd0, ADD_CODE});
      end
      checkResult(vecs[v].name, vecs[v].prod, 1'b0);
    end

    // A second start during RUN is ignored.
    applyStimulus(32'd7, 32'd9, 1'b0, 10, 0);
    checkResult("ignoreStart", 64'd63, 1'b0);

    // Reset in the middle of an operation abandons it.
    applyStimulus(32'd5, 32'd5, 1'b0, 0, 15);
    @(negedge clk);
    rst_n = 1'b1;
    gotDone = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) gotDone = 1'b1;
    end
    checkOutput("noDoneAfterReset", {63'd0, gotDone}, 64'd0);
    applyStimulus(32'd4, 32'd4, 1'b0, 0, 0);
    checkResult("afterReset4x4", 64'd16, 1'b0);

    // Start accepted in the DONE cycle: back-to-back operations.
    applyStimulus(32'd5, 32'd5, 1'b0, 0, 0);
    checkResult("b2bFirst", 64'd25, 1'b1);
    applyStimulus(32'd6, 32'd7, 1'b0, 0, 0);
    checkResult("b2bSecond", 64'd42, 1'b0);

`ifdef MULT_SEQ_SIGNED_EN
    // Signed mode.
    applyStimulus(32'hFFFF_FFFE, 32'd3, 1'b1, 0, 0);
    checkResult("sgnNeg2x3", 64'hFFFF_FFFF_FFFF_FFFA, 1'b0);
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 0);
    checkResult("sgnMinxNeg1", 64'h0000_0000_8000_0000, 1'b0);
    applyStimulus(32'hFFFF_FFFD, 32'hFFFF_FFFB, 1'b1, 0, 0);
    checkResult("sgnNeg3xNeg5", 64'd15, 1'b0);
    applyStimulus(32'hFFFF_FFFE, 32'd3, 1'b0, 0, 0);
    checkResult("unsInSgnBuild", 64'h0000_0002_FFFF_FFFA, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_seq.md
MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 SHALL have parameter ADD_CODE, default 4'd2; ALU control code for add, driven on alu_ctrl.
REQ-002 SHALL have port clk  input  1  single clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request to begin a multiply.
REQ-005 SHALL have port op_a  input  32  multiplier.
REQ-006 SHALL have port op_b  input  32  multiplicand.
REQ-007 SHALL have port busy  output  1  high while an operation is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse when the result is valid.
REQ-009 SHALL have port hi  output  32  upper product word.
REQ-010 SHALL have port lo  output  32  lower product word.
REQ-011 SHALL have port alu_a  output  32  shared-ALU operand A.
REQ-012 SHALL have port alu_b  output  32  shared-ALU operand B.
REQ-013 SHALL have port alu_ctrl  output  4  shared-ALU control code.
REQ-014 SHALL have port alu_out  input  32  combinational ALU result.

Function
REQ-015 SHALL implement states IDLE, RUN, FIX (present only under the macro) and DONE.
REQ-016 SHALL accept start only in IDLE or DONE; on acceptance latch M=op_b, P_hi=0, P_lo=op_a, count=0, and enter RUN.
REQ-017 SHALL ignore start while in RUN or FIX, leaving the operation and operands unaffected.
REQ-018 SHALL in RUN drive alu_a=P_hi, alu_b=(P_lo[0] ? M : 0) and alu_ctrl=ADD_CODE.
REQ-019 SHALL in RUN compute carry=(alu_out < P_hi, unsigned) and update {P_hi,P_lo} <= {carry, alu_out, P_lo} >> 1 each cycle.
REQ-020 SHALL stay in RUN for exactly 32 cycles (count 0..31), then go to DONE (unsigned) or FIX (signed).
REQ-021 SHALL in IDLE, FIX and DONE drive alu_a=0, alu_b=0, alu_ctrl=ADD_CODE.
REQ-022 SHALL assert busy in RUN and FIX only.
REQ-023 SHALL assert done only in DONE, for exactly one cycle, then move to IDLE unless start is accepted in the same cycle.
REQ-024 SHALL drive hi/lo from {P_hi,P_lo}, valid from the done cycle and held until the next accepted start.
REQ-025 SHALL have latency: start sampled at edge 0 -> done high in the cycle after edge 32 (unsigned) or after edge 33 (signed).

Reset
REQ-026 SHALL on rst_n low immediately enter IDLE and clear P_hi, P_lo, M and count, giving busy=0, done=0, hi=0, lo=0, alu_a=0, alu_b=0, alu_ctrl=ADD_CODE.
REQ-027 SHALL on reset mid-operation abandon the operation with no done pulse after release.

Configuration
REQ-028 SHALL, with MULT_SEQ_SIGNED_EN defined, add port signed_op (input, 1, two's-complement mode, latched at start).
REQ-029 SHALL, with MULT_SEQ_SIGNED_EN defined and signed_op=1, load the absolute values of op_a/op_b at start (0x80000000 stays 0x80000000).
REQ-030 SHALL, with MULT_SEQ_SIGNED_EN defined and signed_op=1, record neg=op_a[31]^op_b[31] at start.
REQ-031 SHALL, with MULT_SEQ_SIGNED_EN defined, spend one FIX cycle that 64-bit negates {P_hi,P_lo} if neg=1 (otherwise no change), then go to DONE; with signed_op=0, FIX still costs one cycle with no change.
REQ-032 SHALL, without MULT_SEQ_SIGNED_EN, omit the signed_op port and the FIX state and support unsigned multiplication only.

Verification
REQ-033 SHALL cover: op_a=3, op_b=5, start pulse -> done after 32 RUN cycles; hi=0x00000000, lo=0x0000000F.
REQ-034 SHALL cover: op_a=op_b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 (exercises carry).
REQ-035 SHALL cover: start with 7x9, start again with 2x2 at RUN cycle 10 -> second start ignored; result lo=63; busy high for 32 cycles.
REQ-036 SHALL cover: rst_n low at RUN cycle 15 -> busy=0, hi=lo=0 immediately; no done after release; new 4x4 -> lo=16.
REQ-037 SHALL cover (macro on): signed_op=1, op_a=0xFFFFFFFE (-2), op_b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA; done one cycle later than unsigned.
REQ-038 SHALL cover: start asserted in the DONE cycle with 6x7 -> accepted; done pulses again with lo=42; no IDLE cycle in between.
